// File: rtl/i2c_write_sequencer.sv
// I2C master single-byte write sequencer.
// Generates START, {address, W}, one data byte, both ACK checks and STOP. It sits on
// top of an I2C clock generator: it follows the generator's data_clk phase and gates
// SCL through scl_not_ena. A NACK can retry the whole transaction up to ACK_RETRY times.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   data_clk              generator phase clock (rise = SDA change point, fall = sample point)
//   sda_in                sampled SDA level, used only in the ACK slots
//   req_valid/req_ready   client handshake; req_addr/req_data are captured on accept
//   scl_not_ena           1 = SCL held released high, 0 = SCL toggles
//   sda_oe                1 = pull SDA low, 0 = release SDA
//   busy                  transaction in progress
//   done, ack_err         one-cycle completion pulse; ack_err = NACK after the last retry
module i2c_write_sequencer #(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ACK_RETRY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_clk,
    input  logic              sda_in,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic              scl_not_ena,
    output logic              sda_oe,
    output logic              busy,
    output logic              done,
    output logic              ack_err
);

    // The address frame (ADDR_W + W bit) and the data byte are both DATA_W bits wide.
    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        StIdle, StStart, StAddr, StAddrAck, StData, StDataAck, StStop
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              fail_q, fail_d;
    logic [1:0]        retry_q, retry_d;
    logic              sda_oe_q, sda_oe_d;
    logic              scl_ne_q, scl_ne_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ack_err_q, ack_err_d;
    logic              req_ready_q, req_ready_d;
    logic              dclk_q;

    logic              rtick, ftick;
    logic [ADDR_W:0]   frame;

    assign rtick = data_clk & ~dclk_q;
    assign ftick = ~data_clk & dclk_q;
    assign frame = {addr_q, 1'b0};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= 2'd0;
            bit_cnt_q   <= '0;
            last_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            fail_q      <= 1'b0;
            retry_q     <= 2'd0;
            sda_oe_q    <= 1'b0;
            scl_ne_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            dclk_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            fail_q      <= fail_d;
            retry_q     <= retry_d;
            sda_oe_q    <= sda_oe_d;
            scl_ne_q    <= scl_ne_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ack_err_q   <= ack_err_d;
            req_ready_q <= req_ready_d;
            dclk_q      <= data_clk;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        addr_d    = addr_q;
        data_d    = data_q;
        fail_d    = fail_q;
        retry_d   = retry_q;
        sda_oe_d  = sda_oe_q;
        scl_ne_d  = scl_ne_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Ticks are ignored here, so an rtick on the accept edge is not counted.
                if (req_valid && req_ready_q) begin
                    addr_d  = req_addr;
                    data_d  = req_data;
                    busy_d  = 1'b1;
                    retry_d = 2'd0;
                    fail_d  = 1'b0;
                    phase_d = 2'd0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (rtick) begin
                    if (phase_q == 2'd0) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 2'd1;
                    end else begin
                        scl_ne_d  = 1'b0;
                        bit_cnt_d = CNT_W'(ADDR_W);
                        last_d    = 1'b0;
                        phase_d   = 2'd0;
                        state_d   = StAddr;
                    end
                end
            end
            StAddr: begin
                // bit_cnt is the next bit to drive; last flags that bit 0 is already out.
                if (rtick) begin
                    if (last_q) begin
                        sda_oe_d = 1'b0;
                        phase_d  = 2'd0;
                        state_d  = StAddrAck;
                    end else begin
                        sda_oe_d = ~frame[bit_cnt_q];
                        if (bit_cnt_q == '0) last_d = 1'b1;
                        else bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end
                end
            end
            StAddrAck: begin
                if (phase_q == 2'd0) begin
                    if (ftick) begin
                        if (sda_in) begin
                            fail_d  = 1'b1;
                            phase_d = 2'd0;
                            state_d = StStop;
                        end else begin
                            phase_d = 2'd1;
                        end
                    end
                end else if (rtick) begin
                    // The rtick closing the ACK slot already puts the data MSB on SDA.
                    sda_oe_d  = ~data_q[DATA_W-1];
                    bit_cnt_d = CNT_W'(DATA_W - 2);
                    last_d    = 1'b0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (rtick) begin
                    if (last_q) begin
                        sda_oe_d = 1'b0;
                        state_d  = StDataAck;
                    end else begin
                        sda_oe_d = ~data_q[bit_cnt_q];
                        if (bit_cnt_q == '0) last_d = 1'b1;
                        else bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end
                end
            end
            StDataAck: begin
                if (ftick) begin
                    fail_d  = sda_in;
                    phase_d = 2'd0;
                    state_d = StStop;
                end
            end
            StStop: begin
                // SDA low, then release SCL, then release SDA while SCL is high.
                if (rtick) begin
                    case (phase_q)
                        2'd0: begin
                            sda_oe_d = 1'b1;
                            phase_d  = 2'd1;
                        end
                        2'd1: begin
                            scl_ne_d = 1'b1;
                            phase_d  = 2'd2;
                        end
                        default: begin
                            sda_oe_d = 1'b0;
                            phase_d  = 2'd0;
                            if (fail_q && (32'(retry_q) < ACK_RETRY)) begin
                                retry_d = retry_q + 2'd1;
                                fail_d  = 1'b0;
                                state_d = StStart;
                            end else begin
                                done_d    = 1'b1;
                                ack_err_d = fail_q;
                                busy_d    = 1'b0;
                                state_d   = StIdle;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Ready only once back in idle, so it rises the cycle after done.
    assign req_ready_d = (state_d == StIdle) && !done_d;

    // Outputs
    always_comb begin
        req_ready   = req_ready_q;
        scl_not_ena = scl_ne_q;
        sda_oe      = sda_oe_q;
        busy        = busy_q;
        done        = done_q;
        ack_err     = ack_err_q;
    end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
module tb_i2c_write_sequencer;

    logic       clk;
    logic       rst;
    logic       data_clk;
    logic       sda_in;
    logic       req_valid;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       sel;
    logic       stall;
    logic       nack_all;
    logic       nack_data;

    logic req_valid1, req_ready1, scl_ne1, sda_oe1, busy1, done1, ack_err1;
    logic req_valid2, req_ready2, scl_ne2, sda_oe2, busy2, done2, ack_err2;
    logic m_ready, m_scl_ne, m_sda_oe, m_busy, m_done, m_ack_err;

    int tests_run;
    int tests_failed;

    // Monitor state (written only by the monitor process)
    int          rcnt;
    int          txn_r;
    int          starts;
    int          stops;
    int          done_cnt;
    int          div;
    logic [63:0] sda_log;
    logic [63:0] scl_log;
    logic        pe_prev, busy_prev, oe_prev;

    assign req_valid1 = req_valid & ~sel;
    assign req_valid2 = req_valid & sel;
    assign m_ready    = sel ? req_ready2 : req_ready1;
    assign m_scl_ne   = sel ? scl_ne2 : scl_ne1;
    assign m_sda_oe   = sel ? sda_oe2 : sda_oe1;
    assign m_busy     = sel ? busy2 : busy1;
    assign m_done     = sel ? done2 : done1;
    assign m_ack_err  = sel ? ack_err2 : ack_err1;

    i2c_write_sequencer #(.ADDR_W(7), .DATA_W(8), .ACK_RETRY(0)) dut0 (
        .clk(clk), .rst(rst), .data_clk(data_clk), .sda_in(sda_in),
        .req_valid(req_valid1), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready1), .scl_not_ena(scl_ne1), .sda_oe(sda_oe1),
        .busy(busy1), .done(done1), .ack_err(ack_err1)
    );

    i2c_write_sequencer #(.ADDR_W(7), .DATA_W(8), .ACK_RETRY(2)) dut2 (
        .clk(clk), .rst(rst), .data_clk(data_clk), .sda_in(sda_in),
        .req_valid(req_valid2), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready2), .scl_not_ena(scl_ne2), .sda_oe(sda_oe2),
        .busy(busy2), .done(done2), .ack_err(ack_err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // data_clk generator (8 clk period) plus bus monitor, evaluated on negedge.
    initial begin
        data_clk = 1'b0; sda_in = 1'b0; div = 0;
        rcnt = 0; txn_r = 0; starts = 0; stops = 0; done_cnt = 0;
        sda_log = '0; scl_log = '0;
        pe_prev = 1'b0; busy_prev = 1'b0; oe_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (data_clk && !pe_prev && busy_prev) begin
                rcnt++;
                txn_r++;
                sda_log = {sda_log[62:0], m_sda_oe};
                scl_log = {scl_log[62:0], m_scl_ne};
            end
            pe_prev = data_clk;
            if (!busy_prev && m_busy) txn_r = 0;
            if (m_scl_ne && !oe_prev && m_sda_oe) starts++;
            if (m_scl_ne && oe_prev && !m_sda_oe) stops++;
            if (m_done) done_cnt++;
            oe_prev   = m_sda_oe;
            busy_prev = m_busy;
            sda_in = nack_all || (nack_data && (txn_r >= 12));
            if (!stall) begin
                div++;
                if (div == 4) begin
                    div = 0;
                    data_clk = ~data_clk;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_txn(input logic s, input logic [6:0] a, input logic [7:0] d,
                           input bit hold, input int stall_at, input int n,
                           input logic [63:0] exp_sda, input logic [63:0] exp_scl,
                           input logic exp_err, input int exp_starts, input string name);
        int r0, d0, s0, p0, rs;
        bit ok, changed;
        logic oe_s, ne_s;
        logic [63:0] mask;
        sel = s;
        @(posedge clk); #1;
        r0 = rcnt; d0 = done_cnt; s0 = starts; p0 = stops;
        req_addr = a; req_data = d; req_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge clk); #1;
            ok = m_busy;
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s accept: busy=0 required 1", name);
        end
        if (hold) begin
            // Request still asserted while busy, with different payload: must be ignored.
            req_addr = 7'h7F; req_data = 8'h00;
            repeat (40) @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (stall_at > 0) begin
            ok = 1'b0;
            for (int c = 0; c < 1000 && !ok; c++) begin
                @(posedge clk); #1;
                ok = (txn_r >= stall_at) && data_clk;
            end
            stall = 1'b1;
            oe_s = m_sda_oe; ne_s = m_scl_ne; rs = txn_r; changed = !ok;
            repeat (500) begin
                @(posedge clk); #1;
                if (m_sda_oe !== oe_s || m_scl_ne !== ne_s || m_done || !m_busy) changed = 1'b1;
            end
            stall = 1'b0;
            tests_run++;
            if (changed || txn_r != rs) begin
                tests_failed++;
                $display("FAIL %s stall: changed=%0d rticks %0d->%0d required no change",
                         name, changed, rs, txn_r);
            end
        end
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(posedge clk); #1;
            ok = m_done;
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s done: no done pulse within budget", name);
        end else begin
            tests_run++;
            if (m_ack_err !== exp_err || m_busy !== 1'b0 || m_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s done_flags: ack_err=%b busy=%b ready=%b required %b 0 0",
                         name, m_ack_err, m_busy, m_ready, exp_err);
            end
            @(posedge clk); #1;
            tests_run++;
            if (m_ready !== 1'b1 || m_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s after_done: ready=%b done=%b required 1 0", name, m_ready, m_done);
            end
        end
        repeat (30) @(posedge clk);
        #1;
        mask = (64'd1 << n) - 64'd1;
        tests_run++;
        if (rcnt - r0 != n) begin
            tests_failed++;
            $display("FAIL %s rticks: got %0d required %0d", name, rcnt - r0, n);
        end
        tests_run++;
        if ((sda_log & mask) !== exp_sda) begin
            tests_failed++;
            $display("FAIL %s sda_seq: got %h required %h", name, sda_log & mask, exp_sda);
        end
        tests_run++;
        if ((scl_log & mask) !== exp_scl) begin
            tests_failed++;
            $display("FAIL %s scl_seq: got %h required %h", name, scl_log & mask, exp_scl);
        end
        tests_run++;
        if (done_cnt - d0 != 1) begin
            tests_failed++;
            $display("FAIL %s done_count: got %0d required 1", name, done_cnt - d0);
        end
        tests_run++;
        if (starts - s0 != exp_starts || stops - p0 != exp_starts) begin
            tests_failed++;
            $display("FAIL %s start_stop: got %0d/%0d required %0d/%0d",
                     name, starts - s0, stops - p0, exp_starts, exp_starts);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({req_ready1, scl_ne1, sda_oe1, busy1, done1, ack_err1} !== 6'b110000) begin
            tests_failed++;
            $display("FAIL reset_dut0: got %b required 110000",
                     {req_ready1, scl_ne1, sda_oe1, busy1, done1, ack_err1});
        end
        tests_run++;
        if ({req_ready2, scl_ne2, sda_oe2, busy2, done2, ack_err2} !== 6'b110000) begin
            tests_failed++;
            $display("FAIL reset_dut2: got %b required 110000",
                     {req_ready2, scl_ne2, sda_oe2, busy2, done2, ack_err2});
        end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_write();
        run_txn(1'b0, 7'h50, 8'hA5, 1'b1, 0, 23,
                64'(23'b11_01011111_0_01011010_0_110),
                64'(23'b10_00000000_0_00000000_0_011), 1'b0, 1, "basic");
    endtask

    task automatic test_addr_nack();
        nack_all = 1'b1;
        run_txn(1'b0, 7'h3C, 8'h99, 1'b0, 0, 14,
                64'(14'b11_10000111_0_110),
                64'(14'b10_00000000_0_011), 1'b1, 1, "addr_nack");
        nack_all = 1'b0;
    endtask

    task automatic test_retry();
        nack_all = 1'b1;
        run_txn(1'b1, 7'h3C, 8'h99, 1'b0, 0, 42,
                64'({3{14'b11_10000111_0_110}}),
                64'({3{14'b10_00000000_0_011}}), 1'b1, 3, "retry");
        nack_all = 1'b0;
        sel = 1'b0;
    endtask

    task automatic test_data_nack();
        nack_data = 1'b1;
        run_txn(1'b0, 7'h2A, 8'h0F, 1'b0, 0, 23,
                64'(23'b11_10101011_0_11110000_0_110),
                64'(23'b10_00000000_0_00000000_0_011), 1'b1, 1, "data_nack");
        nack_data = 1'b0;
    endtask

    task automatic test_reset_mid_data();
        bit ok;
        sel = 1'b0;
        @(posedge clk); #1;
        req_addr = 7'h50; req_data = 8'hA5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(posedge clk); #1;
            ok = busy1 && (txn_r >= 15);
        end
        // Data bit 4 of 8'hA5 is 0, so SDA is being pulled low.
        tests_run++;
        if (!ok || sda_oe1 !== 1'b1 || scl_ne1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_data_bit4: reached=%0d sda_oe=%b scl_ne=%b required 1 1 0",
                     ok, sda_oe1, scl_ne1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if ({sda_oe1, scl_ne1, busy1, req_ready1} !== 4'b0101) begin
            tests_failed++;
            $display("FAIL mid_reset: sda_oe/scl_ne/busy/ready got %b required 0101",
                     {sda_oe1, scl_ne1, busy1, req_ready1});
        end
        repeat (10) @(posedge clk);
        #1;
        run_txn(1'b0, 7'h50, 8'hA5, 1'b0, 0, 23,
                64'(23'b11_01011111_0_01011010_0_110),
                64'(23'b10_00000000_0_00000000_0_011), 1'b0, 1, "after_reset");
    endtask

    task automatic test_stretch();
        run_txn(1'b0, 7'h11, 8'hC3, 1'b0, 6, 23,
                64'(23'b11_11011101_0_00111100_0_110),
                64'(23'b10_00000000_0_00000000_0_011), 1'b0, 1, "stretch");
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
        sel = 1'b0; stall = 1'b0; nack_all = 1'b0; nack_data = 1'b0;
        test_reset();
        test_basic_write();
        test_addr_nack();
        test_retry();
        test_data_nack();
        test_reset_mid_data();
        test_stretch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/i2c_write_sequencer.md
Name: i2c_write_sequencer

Overview:
- Byte-level I2C master write controller that sequences START, 7-bit address + W bit, one data byte, ACK checks and STOP.
- Sits on top of the team's stretch-capable I2C clock generator: it consumes that generator's data_clk phase output and drives the generator's scl_not_ena input.
- Drives SDA open-drain via an output-enable; samples SDA for ACK.
- Accepts one write request at a time from a valid/ready client port.

Parameters:
- ADDR_W, 7, slave address width (fixed I2C 7-bit addressing).
- DATA_W, 8, data byte width.
- ACK_RETRY, 0, retries of the whole transaction after a NACK, 0 to 3.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- data_clk  input  1  phase clock from the I2C clock generator; high spans 2nd half of SCL-low plus 1st half of SCL-high
- sda_in  input  1  sampled SDA line level
- req_valid  input  1  client request valid
- req_addr  input  7  slave address
- req_data  input  8  byte to write
- req_ready  output  1  sequencer can accept a request
- scl_not_ena  output  1  1 = generator holds SCL released high; 0 = SCL toggles
- sda_oe  output  1  1 = pull SDA low; 0 = release SDA
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse at transaction end
- ack_err  output  1  valid with done; 1 = NACK after final retry

Behaviour:
- Reset (rst=1 at a clk edge), synchronous, overriding everything including mid-transaction: state=IDLE, req_ready=1, scl_not_ena=1, sda_oe=0, busy=0, done=0, ack_err=0, retry count=0, data_clk history register=0.
- Edge detection: data_clk registered once.
  - rtick = data_clk & ~prev is the SDA change point.
  - ftick = ~data_clk & prev is the SDA sample point, mid-SCL-high.
  - All state advances occur only on ticks, except the accept in IDLE.
- Bit order: MSB first. Frame = {req_addr, 1'b0}, then req_data.
- IDLE: req_ready=1. If req_valid&req_ready, capture addr/data on that clk edge, set busy=1, clear retry count, clear req_ready the next cycle, and go to START.
- START: scl_not_ena=1. At the first rtick, set sda_oe=1 (START: SDA falls with SCL high). At the next rtick, set scl_not_ena=0, bit_cnt=7, and go to ADDR.
- ADDR: at each rtick, sda_oe=~frame[bit_cnt]. The rtick after bit 0 has been driven goes to ADDR_ACK with sda_oe=0.
- ADDR_ACK: at ftick, sample sda_in.
  - 0: ACK. At the next rtick, go to DATA with bit_cnt=7.
  - 1: NACK. Go to STOP and mark the failure.
- DATA: same bit handling as ADDR using req_data, then DATA_ACK.
- DATA_ACK: at ftick, sample sda_in. Go to STOP, marking NACK if sda_in=1.
- STOP:
  - rtick: sda_oe=1.
  - next rtick: scl_not_ena=1.
  - next rtick: sda_oe=0 (STOP: SDA rises with SCL high).
  - Then one of:
    - Failure with retry count < ACK_RETRY: increment count, go to START.
    - Otherwise: pulse done for one cycle with ack_err = failure flag, busy=0, go to IDLE. req_ready=1 from the cycle after done.
- req_valid while busy is ignored; no queueing.
- A data_clk stall (generator stretching) simply delays ticks. There is no timeout.
- Simultaneous rtick and req_valid in IDLE: accept the request; that rtick is not counted toward START.
- Exact transaction tick counts, no retry: 1 + 1 + 8 + 1 + 8 + 1 + 3 rticks from accept to done.

Test Plan:
- Reset, then req addr=7'h50 data=8'hA5, sda_in tied 0 -> SDA bit sequence 1010000_0, ACK, 10100101, ACK; done pulses once with ack_err=0; busy high throughout, and for exactly 23 rticks.
- Address NACK (sda_in=1 throughout), ACK_RETRY=0 -> STOP directly after the ADDR_ACK slot, no data bits driven, done with ack_err=1.
- ACK_RETRY=2, sda_in=1 -> three START/STOP sequences observed, then a single done with ack_err=1.
- Data NACK only (sda_in=0 at the address ACK, 1 at the data ACK) -> full data byte sent, done with ack_err=1.
- rst asserted mid-DATA bit 4 -> next cycle: sda_oe=0, scl_not_ena=1, busy=0, req_ready=1; a new request afterwards completes normally.
- data_clk held high 500 cycles mid-ADDR (stretch) -> no state change, no spurious done; transfer resumes and completes correctly.
